// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO with req/ack handshakes on both
// ports, a registered fill-level counter, programmable almost-full/almost-empty
// thresholds and a synchronous flush. Flags are decoded from the level counter.
module param_fifo #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     writeReq,
  input  logic [WIDTH-1:0]         dataIn,
  output logic                     writeAck,
  input  logic                     readReq,
  output logic                     readAck,
  output logic [WIDTH-1:0]         dataOut,
  input  logic                     flush,
  output logic                     empty,
  output logic                     full,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

  // Storage array; contents are not reset, only the pointers and level are.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wack_q, wack_d;
  logic             rack_q, rack_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             empty_w;
  logic             full_w;
  logic             wr_en;
  logic             rd_en;

  // Status flags decoded purely from the registered level.
  always_comb begin
    empty_w     = (level_q == '0);
    full_w      = (level_q == FULL_LVL);
    almostFull  = (level_q >= AF_LVL);
    almostEmpty = (level_q <= AE_LVL);
  end

  assign empty    = empty_w;
  assign full     = full_w;
  assign level    = level_q;
  assign writeAck = wack_q;
  assign readAck  = rack_q;
  assign dataOut  = dout_q;

  // Accept decisions: a pending ack blanks its port for one cycle so a
  // still-held request is not counted twice; flush blocks both ports.
  always_comb begin
    wr_en = writeReq && !wack_q && !full_w  && !flush;
    rd_en = readReq  && !rack_q && !empty_w && !flush;
  end

  // Next-state computation for pointers, level, acks and read data.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    dout_d  = dout_q;
    wack_d  = wr_en;
    rack_d  = rd_en;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (rd_en) begin
        rptr_d = rptr_q + AW'(1);
        dout_d = mem_q[rptr_q];
      end
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control and data-out registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      wack_q  <= wack_d;
      rack_q  <= rack_d;
      dout_q  <= dout_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= dataIn;
    end
  end

endmodule
